// File: rtl/vram_arbiter.sv
// Video RAM port arbiter: video fetches own every ce clock, CPU reads and
// multi-bank writes are interleaved on the remaining clocks.
`timescale 1ns/1ps
module vram_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   input  logic [1:0]  vb,
   input  logic [12:0] va,
   output logic [7:0]  vd,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [12:0] cpu_a,
   input  logic [3:0]  cpu_bank,
   input  logic [7:0]  cpu_d,
   output logic [7:0]  cpu_q,
   output logic        cpu_ack,
   output logic [14:0] ram_a,
   output logic [7:0]  ram_d,
   output logic        ram_we,
   input  logic [7:0]  ram_q
);

   localparam int unsigned AddrW = 13;
   localparam int unsigned BankW = 4;
   localparam int unsigned DataW = 8;

   typedef enum logic [2:0] {IDLE, WR, RD, RDW, ACK} stateT;

   stateT             state, nextState;
   logic [BankW-1:0]  cmask, cmaskNext;
   logic [AddrW-1:0]  cAddr;
   logic [DataW-1:0]  cData;
   logic              vpend;

   function automatic logic [BankW-1:0] lowBit(input logic [BankW-1:0] m);
      return m & (~m + BankW'(1));
   endfunction

   function automatic logic [1:0] lowIdx(input logic [BankW-1:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // State, latched request, video capture and CPU read data
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cmask   <= '0;
         cAddr   <= '0;
         cData   <= '0;
         vpend   <= 1'b0;
         vd      <= '0;
         cpu_q   <= '0;
         cpu_ack <= 1'b0;
      end else begin
         state   <= nextState;
         cmask   <= cmaskNext;
         cpu_ack <= (nextState == ACK);
         vpend   <= ce;
         if (vpend) vd <= ram_q;
         if (state == IDLE && cpu_req) begin
            cAddr <= cpu_a;
            cData <= cpu_d;
         end
         if (state == RDW)
            cpu_q <= ram_q;
         else if (state == IDLE && cpu_req && !cpu_we && cpu_bank == '0)
            cpu_q <= 8'hFF;
      end
   end

   // Next state and RAM port mux; a ce clock always hands the port to video
   always_comb begin
      nextState = state;
      cmaskNext = cmask;
      ram_a     = '0;
      ram_d     = '0;
      ram_we    = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               cmaskNext = cpu_we ? cpu_bank : lowBit(cpu_bank);
               if (cpu_bank == '0) nextState = ACK;
               else if (cpu_we)    nextState = WR;
               else                nextState = RD;
            end
         end
         WR: begin
            if (!ce) begin
               ram_we    = 1'b1;
               ram_a     = {lowIdx(cmask), cAddr};
               ram_d     = cData;
               cmaskNext = cmask & ~lowBit(cmask);
               if (cmaskNext == '0) nextState = ACK;
            end
         end
         RD: begin
            if (!ce) begin
               ram_a     = {lowIdx(cmask), cAddr};
               nextState = RDW;
            end
         end
         RDW:     nextState = ACK;
         ACK:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
      if (ce) begin
         ram_a  = {vb, va};
         ram_d  = '0;
         ram_we = 1'b0;
      end
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Video RAM port arbiter for the Lynx 48 core. It is the memory-side responder to the video fetch port (`b`/`a` in, `d` out). It also services CPU reads and multi-bank CPU writes into one shared synchronous 32 KB video RAM. Video fetches always win the clock on which `ce` is high. CPU accesses are interleaved on the remaining clocks under a req/ack handshake.

## Interface
Parameters: none.

- `clock` — in, 1 — system clock; single clock domain.
- `reset` — in, 1 — asynchronous, active-low reset.
- `ce` — in, 1 — video pixel enable, the same strobe used by the video generator. Never high on two consecutive clocks.
- `vb` — in, 2 — video bank select: 0 blue, 1 red, 2 alt-green, 3 green.
- `va` — in, 13 — video address {line[7:0], column[4:0]}.
- `vd` — out, 8 — video read data, held stable between fetches.
- `cpu_req` — in, 1 — CPU access request, level.
- `cpu_we` — in, 1 — 1 = write, 0 = read; sampled with the request.
- `cpu_a` — in, 13 — CPU bank-relative address.
- `cpu_bank` — in, 4 — bank mask; bit n selects bank n.
- `cpu_d` — in, 8 — CPU write data.
- `cpu_q` — out, 8 — CPU read data; valid from the ack clock until the next read completes.
- `cpu_ack` — out, 1 — one-clock completion pulse.
- `ram_a` — out, 15 — RAM address {bank[1:0], addr[12:0]}.
- `ram_d` — out, 8 — RAM write data.
- `ram_we` — out, 1 — RAM write enable.
- `ram_q` — in, 8 — RAM read data. The RAM is synchronous with 1-clock read latency.

## Operation
- **RAM mux (combinational).**
  - When `ce`=1: `ram_a`={`vb`,`va`}, `ram_we`=0.
  - Otherwise the CPU FSM drives the RAM. When the FSM is not issuing, `ram_a`=0 and `ram_we`=0.
- **Video path.**
  - A flag `vpend` is set on every `ce` clock.
  - On the following clock, `vd` <= `ram_q` and `vpend` clears.
- **CPU FSM states:** IDLE, WR, RD, RDW, ACK.
- **IDLE:**
  - On `cpu_req`=1, latch `cpu_a`, `cpu_d`, `cpu_we`, and `cpu_bank` into `cmask`.
  - Write → WR.
  - Read → RD. For reads, `cmask` keeps only the lowest set bit.
  - `cpu_bank`=0 → ACK directly. No RAM cycle occurs, and a read returns `cpu_q`=8'hFF.
- **WR:** on each clock with `ce`=0:
  - Drive `ram_we`=1, `ram_a`={index of lowest set bit of `cmask`, latched addr}, `ram_d`=latched data.
  - Clear that bit.
  - Go to ACK when `cmask` becomes 0.
  - On a clock with `ce`=1, stall in WR with no CPU write.
- **RD:** on a clock with `ce`=0, drive `ram_a` and go to RDW. On a `ce`=1 clock, stall.
- **RDW:** `cpu_q` <= `ram_q` at the end of this clock, regardless of `ce`; go to ACK.
- **ACK:** `cpu_ack`=1 for exactly one clock, then IDLE.
  - The requester drops `cpu_req` during the ACK clock.
  - If `cpu_req` is still high in IDLE, it is a new transaction.
- **Reset values:** state IDLE, `cmask`=0, `vpend`=0, `vd`=0, `cpu_q`=0, `cpu_ack`=0, `ram_we`=0.
- **Reset mid-transaction:** the transaction is aborted. Banks not yet written stay unwritten, and no ack is given.

## Timing
- **Video:** address presented on the `ce` clock t. `vd` updates at the end of clock t+1, which is before the next `ce`.
- **CPU write with k banks and no intervening `ce`:**
  - Request sampled at edge 0.
  - Writes on clocks 1..k.
  - `cpu_ack` on clock k+1.
  - Each `ce` clock during WR adds 1 clock.
- **CPU read with no `ce`:** RD on clock 1, RDW on clock 2, ack on clock 3 with `cpu_q` valid. A `ce` clock during RD adds 1.
- **Read issued on the clock right before a `ce` clock:** the video address does not disturb the pending CPU data; RDW captures `ram_q` for the CPU address.
- **Write ordering:** banks are written in ascending bank index.

## Test plan
- **Video fetch:** RAM preloaded with {0x0A5C}=0x3C in bank 1; `ce` every 4 clocks, `vb`=1, `va`=0x0A5C → `ram_a`=0x2A5C on the `ce` clock; `vd`=0x3C one clock later, held until the next fetch.
- **Multi-bank write:** `cpu_bank`=4'b1011, `cpu_a`=0x0100, `cpu_d`=0x55, `ce` low → writes to `ram_a` 0x0100, 0x2100, 0x6100 on clocks 1–3; `cpu_ack` on clock 4.
- **Write stalled by video:** same write with `ce` high on clock 2 → clock 2 carries the video address with `ram_we`=0; the writes complete on clocks 1, 3, 4; ack on clock 5.
- **CPU read:** `cpu_bank`=4'b0110, `cpu_a`=0x1FFF, RAM holds 0x81 at 0x3FFF → only bank 1 is read; `cpu_q`=0x81 with ack on clock 3.
- **Empty mask:** `cpu_bank`=0 read → no `ram_we` and no CPU address; ack on clock 1 with `cpu_q`=0xFF.
- **Reset mid-write:** `reset` low after the first bank of mask 4'b1111 is written → only bank 0 is modified; no ack; all outputs at reset values; state IDLE after release.
